led_pwm_fader: RTL and testbench



---
 rtl/led_pkg.sv | 20 ++
 rtl/pwm_fade_channel.sv | 57 +++++
 rtl/led_pwm_fader.sv | 70 +++++++
 tb/tb_led_pwm_fader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared defaults and helpers for the LED PWM fader.
// Pure constants and functions, so there is no latency or backpressure here.
package led_pkg;

  localparam int DEF_NUM_LEDS  = 4;
  localparam int DEF_PWM_WIDTH = 8;
  localparam int DEF_STEP_DIV  = 97_656;

  // Direction a channel's duty moves on the next step tick.
  typedef enum logic [1:0] {
    FADE_HOLD = 2'd0,
    FADE_UP   = 2'd1,
    FADE_DOWN = 2'd2
  } fade_dir_t;

  function automatic int duty_max(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/pwm_fade_channel.sv
// One LED channel: duty register stepping toward 0 or full scale, plus the PWM output flop.
// led is one cycle behind pwm_cnt/duty; there is no backpressure, duty moves only on step_tick.
module pwm_fade_channel
  import led_pkg::*;
#(
  parameter int PWM_WIDTH = DEF_PWM_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 step_tick,
  input  logic                 target_on,
  input  logic [PWM_WIDTH-1:0] pwm_cnt,
  output logic                 led,
  output logic                 at_target
);

  localparam logic [PWM_WIDTH-1:0] DUTY_MAX = PWM_WIDTH'(duty_max(PWM_WIDTH));

  logic [PWM_WIDTH-1:0] duty;
  logic [PWM_WIDTH-1:0] target;
  fade_dir_t            dir;

  assign target    = target_on ? DUTY_MAX : '0;
  assign at_target = (duty == target);

  // Target is only ever an endpoint, so moving toward it can never wrap.
  always_comb begin
    dir = FADE_HOLD;
    if (duty < target) begin
      dir = FADE_UP;
    end else if (duty > target) begin
      dir = FADE_DOWN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty <= '0;
    end else if (step_tick) begin
      case (dir)
        FADE_UP:   duty <= duty + 1'b1;
        FADE_DOWN: duty <= duty - 1'b1;
        default:   duty <= duty;
      endcase
    end
  end

  // Full scale forces a solid on; otherwise pwm_cnt < duty gives exactly duty highs per period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= 1'b0;
    end else begin
      led <= (duty == DUTY_MAX) | (pwm_cnt < duty);
    end
  end

endmodule

// File: rtl/led_pwm_fader.sv
// Cross-fades each LED between off and full brightness following a registered on/off pattern.
// led_out lags pattern_q by the fade time plus one cycle; no backpressure, enable=0 only freezes the fade.
module led_pwm_fader
  import led_pkg::*;
#(
  parameter int NUM_LEDS  = DEF_NUM_LEDS,
  parameter int PWM_WIDTH = DEF_PWM_WIDTH,
  parameter int STEP_DIV  = DEF_STEP_DIV,
  parameter int DIV_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [NUM_LEDS-1:0] pattern_in,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                busy
);

  localparam logic [DIV_WIDTH-1:0] STEP_LAST = DIV_WIDTH'(STEP_DIV - 1);

  logic [NUM_LEDS-1:0]  pattern_q;
  logic [PWM_WIDTH-1:0] pwm_cnt;
  logic [DIV_WIDTH-1:0] step_cnt;
  logic                 step_tick;
  logic [NUM_LEDS-1:0]  at_target;

  // Same clock domain as the pattern source, so a single register is enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_q <= '0;
    end else begin
      pattern_q <= pattern_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  assign step_tick = enable && (step_cnt == STEP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt <= '0;
    end else if (enable) begin
      step_cnt <= (step_cnt == STEP_LAST) ? '0 : step_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
    pwm_fade_channel #(
      .PWM_WIDTH(PWM_WIDTH)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .step_tick(step_tick),
      .target_on(pattern_q[i]),
      .pwm_cnt  (pwm_cnt),
      .led      (led_out[i]),
      .at_target(at_target[i])
    );
  end

  assign busy = ~&at_target;

endmodule

// File: tb/tb_led_pwm_fader.sv
// Scoreboard bench: a slow-step and a fast-step fader share stimulus and are checked against a reference model.
module tb_led_pwm_fader;

  localparam int NL   = 4;
  localparam int DMAX = 15;
  localparam int NPWM = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] pattern_in = 4'h0;
  logic [3:0] led_a, led_b;
  logic       busy_a, busy_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  led_pwm_fader #(.NUM_LEDS(4), .PWM_WIDTH(4), .STEP_DIV(4), .DIV_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_in(pattern_in),
    .led_out(led_a), .busy(busy_a));

  led_pwm_fader #(.NUM_LEDS(4), .PWM_WIDTH(4), .STEP_DIV(1), .DIV_WIDTH(8)) dut_fast (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_in(pattern_in),
    .led_out(led_b), .busy(busy_b));

  typedef struct {
    logic [3:0] la;
    logic       ba;
    logic [3:0] lb;
    logic       bb;
    int         idx;
  } exp_t;

  exp_t exp_q[$];
  int   cyc_no = 0;

  // Reference model: [0] = STEP_DIV 4, [1] = STEP_DIV 1.
  int         div_m[2] = '{4, 1};
  int         duty_m[2][NL];
  int         time_m[2];
  int         enab_m[2];
  logic [3:0] pq_m[2];
  logic [3:0] led_m[2];
  logic       tick_m[2];

  function automatic logic model_busy(input int k);
    for (int i = 0; i < NL; i++)
      if (duty_m[k][i] != (pq_m[k][i] ? DMAX : 0)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NL; i++) duty_m[k][i] = 0;
      time_m[k] = 0; enab_m[k] = 0; pq_m[k] = '0; led_m[k] = '0; tick_m[k] = 1'b0;
    end
  endtask

  // One rising edge of the spec's rules, using the values held just before the edge.
  task automatic model_step(input logic en, input logic [3:0] pat);
    int tgt;
    for (int k = 0; k < 2; k++) begin
      tick_m[k] = en && (((enab_m[k] + 1) % div_m[k]) == 0);
      for (int i = 0; i < NL; i++) begin
        led_m[k][i] = (duty_m[k][i] == DMAX) || ((time_m[k] % NPWM) < duty_m[k][i]);
        tgt = pq_m[k][i] ? DMAX : 0;
        if (tick_m[k]) begin
          if (duty_m[k][i] < tgt) duty_m[k][i]++;
          else if (duty_m[k][i] > tgt) duty_m[k][i]--;
        end
      end
      pq_m[k] = pat;
      time_m[k]++;
      if (en) enab_m[k]++;
    end
  endtask

  task automatic cycle(input logic r, input logic en, input logic [3:0] pat);
    exp_t e;
    @(negedge clk);
    rst_n = r; enable = en; pattern_in = pat;
    if (!r) model_reset();
    else model_step(en, pat);
    e.la = led_m[0]; e.ba = model_busy(0);
    e.lb = led_m[1]; e.bb = model_busy(1);
    e.idx = cyc_no++;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic bound_fail(input string name);
    tests++; fails++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Monitor: the DUT presents outputs every cycle, compared just after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if ({e.la, e.ba, e.lb, e.bb} !== {led_a, busy_a, led_b, busy_b}) begin
          fails++;
          $display("FAIL scoreboard cyc %0d: got led_a=%b busy_a=%b led_b=%b busy_b=%b, expected led_a=%b busy_a=%b led_b=%b busy_b=%b",
                   e.idx, led_a, busy_a, led_b, busy_b, e.la, e.ba, e.lb, e.bb);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int highs, rises;
    logic [15:0] win;
    logic seen;
    int hold;
    logic [3:0] pat;
    logic en;

    model_reset();
    #2 rst_n = 1'b0;
    for (int c = 0; c < 5; c++) cycle(1'b0, 1'b1, 4'hF);

    // Fade up channel 0.
    for (int c = 0; c < 64; c++) cycle(1'b1, 1'b1, 4'b0001);
    #2;
    check("fadeup_led", {4'h0, led_a}, 8'h01);
    check("fadeup_busy", {7'h0, busy_a}, 8'h00);

    // Asynchronous reset between edges.
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_led", {led_b, led_a}, 8'h00);
    check("async_rst_busy", {6'h0, busy_b, busy_a}, 8'h00);
    model_reset();
    cycle(1'b0, 1'b0, 4'h0);

    // Fast step on all channels.
    for (int c = 0; c < 18; c++) cycle(1'b1, 1'b1, 4'hF);
    #2;
    check("fast_led", {4'h0, led_b}, 8'h0F);
    check("fast_busy", {7'h0, busy_b}, 8'h00);
    check("slow_still_busy", {7'h0, busy_a}, 8'h01);

    // Duty accuracy at 8/16.
    cycle(1'b0, 1'b0, 4'h0);
    n = 0;
    while (duty_m[0][0] != 8 && n < 200) begin cycle(1'b1, 1'b1, 4'b0001); n++; end
    if (duty_m[0][0] != 8) bound_fail("duty8_wait");
    for (int c = 0; c < 3; c++) cycle(1'b1, 1'b0, 4'b0001);
    for (int c = 0; c < 16; c++) begin
      cycle(1'b1, 1'b0, 4'b0001);
      #2 win[c] = led_a[0];
    end
    highs = 0; rises = 0;
    for (int c = 0; c < 16; c++) begin
      if (win[c]) highs++;
      if (win[c] && !win[(c + 15) % 16]) rises++;
    end
    check("duty8_highs", 8'(highs), 8'd8);
    check("duty8_runs", 8'(rises), 8'd1);

    // Reversal from duty 5 while rising.
    cycle(1'b0, 1'b0, 4'h0);
    n = 0;
    while (duty_m[0][0] != 5 && n < 200) begin cycle(1'b1, 1'b1, 4'b0001); n++; end
    if (duty_m[0][0] != 5) bound_fail("duty5_wait");
    n = 0;
    while (model_busy(0) && n < 200) begin cycle(1'b1, 1'b1, 4'b0000); n++; end
    if (model_busy(0)) bound_fail("reversal_wait");
    cycle(1'b1, 1'b1, 4'b0000);
    cycle(1'b1, 1'b1, 4'b0000);
    #2;
    check("reversal_led", {4'h0, led_a}, 8'h00);
    check("reversal_busy", {7'h0, busy_a}, 8'h00);

    // Two-cycle glitch on channel 1 between ticks.
    n = 0;
    cycle(1'b1, 1'b1, 4'b0000);
    while (!tick_m[0] && n < 10) begin cycle(1'b1, 1'b1, 4'b0000); n++; end
    if (!tick_m[0]) bound_fail("glitch_align");
    seen = 1'b0;
    cycle(1'b1, 1'b1, 4'b0010);
    #2 seen |= led_a[1];
    cycle(1'b1, 1'b1, 4'b0010);
    #2 seen |= led_a[1];
    for (int c = 0; c < 10; c++) begin
      cycle(1'b1, 1'b1, 4'b0000);
      #2 seen |= led_a[1];
    end
    check("glitch_led1", {7'h0, seen}, 8'h00);

    // Randomised pattern and enable.
    hold = 0; pat = 4'h0;
    for (int c = 0; c < 600; c++) begin
      if (hold == 0) begin
        pat  = 4'($urandom_range(0, 15));
        hold = $urandom_range(1, 40);
      end
      hold--;
      en = ($urandom_range(0, 3) != 0);
      cycle(1'b1, en, pat);
    end

    @(negedge clk);
    check("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
